// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown hazard unit; define HAZARD_FWD_EN for load-use-only stalling
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int CNT_W      = 16,
    parameter bit ZERO_REG   = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       id_valid_i,
    input  logic [REG_ADDR_W-1:0]      src1_i,
    input  logic [REG_ADDR_W-1:0]      src2_i,
    input  logic                       is_imm_i,
    input  logic                       st_or_bne_i,
    input  logic [REG_ADDR_W-1:0]      dest_i,
    input  logic                       wb_en_i,
    input  logic                       mem_r_en_i,
    input  logic                       freeze_i,
    input  logic                       flush_i,
    output logic                       stall_o,
    output logic [(1<<REG_ADDR_W)-1:0] pending_o,
    output logic [CNT_W-1:0]           stall_cycles_o
);
    localparam int NUM_REGS = 1 << REG_ADDR_W;
    localparam int CW = $clog2(PIPE_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH = CW'(PIPE_DEPTH);

    logic [CW-1:0]       cnt_q [NUM_REGS];
    logic [CW-1:0]       cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] ld_q, ld_d;
    logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;
    logic                busy1, busy2, issue, dest_ok;

    // hazard detection on the ID-stage sources and issue qualification
    always_comb begin
`ifdef HAZARD_FWD_EN
        busy1 = ld_q[src1_i] && cnt_q[src1_i] == DEPTH;
        busy2 = ld_q[src2_i] && cnt_q[src2_i] == DEPTH;
`else
        busy1 = cnt_q[src1_i] != '0;
        busy2 = cnt_q[src2_i] != '0;
`endif
        busy1 = busy1 && !(ZERO_REG && src1_i == '0);
        busy2 = busy2 && !(ZERO_REG && src2_i == '0) && (!is_imm_i || st_or_bne_i);
        stall_o = id_valid_i && !flush_i && (busy1 || busy2);
        issue = id_valid_i && !stall_o && !flush_i && !freeze_i;
        dest_ok = wb_en_i && !(ZERO_REG && dest_i == '0);
    end

    // countdown update; a fresh producer overrides the decrement of its register
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            ld_d[r] = ld_q[r];
            if (!freeze_i && cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
                ld_d[r] = ld_q[r] && cnt_q[r] != CW'(1);
            end
            if (issue && dest_ok && dest_i == REG_ADDR_W'(r)) begin
                cnt_d[r] = DEPTH;
                ld_d[r] = mem_r_en_i;
            end
            pending_o[r] = cnt_q[r] != '0;
        end
        stall_cycles_d = (stall_o && !freeze_i && ~&stall_cycles_q) ? stall_cycles_q + CNT_W'(1) : stall_cycles_q;
        stall_cycles_o = stall_cycles_q;
    end

    // state registers with synchronous reset dropping all in-flight tracking
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '{default: '0};
            ld_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            ld_q <= ld_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised, scoreboard-based hazard unit for the pipelined MIPS core, sitting beside the ID stage. It tracks every in-flight register write with a per-register countdown instead of comparing fixed EXE/MEM destination ports. It raises a stall whenever an ID-stage instruction reads a register whose value is not yet obtainable. Pipeline depth and register-file size are parameters, an external freeze is supported, and stall cycles are counted for performance monitoring.

## Interface
- REG_ADDR_W, 4, register address width; NUM_REGS = 2**REG_ADDR_W
- PIPE_DEPTH, 3, cycles from issue out of ID until the result is readable from the register file; legal range 1..15
- CNT_W, 16, width of the stall-cycle counter
- ZERO_REG, 0, when 1, register 0 is never marked pending and never causes a hazard
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- id_valid_i  in  1  a valid instruction is present in ID
- src1_i  in  REG_ADDR_W  first source register
- src2_i  in  REG_ADDR_W  second source register
- is_imm_i  in  1  instruction uses an immediate operand
- st_or_bne_i  in  1  store or BNE; src2 is read despite is_imm_i
- dest_i  in  REG_ADDR_W  destination register
- wb_en_i  in  1  instruction writes dest_i
- mem_r_en_i  in  1  instruction is a load
- freeze_i  in  1  whole pipeline held; scoreboard frozen
- flush_i  in  1  ID instruction is being squashed (taken branch)
- stall_o  out  1  hold ID/IF this cycle (combinational)
- pending_o  out  NUM_REGS  registered per-register busy vector
- stall_cycles_o  out  CNT_W  saturating count of cycles with stall_o=1

## Operation
- State per register r: cnt[r] (width clog2(PIPE_DEPTH+1)) and ld[r] (producer is a load). pending_o[r] = (cnt[r] != 0).
- src2 is used when (!is_imm_i || st_or_bne_i). src1 is always used.
- A source s is busy when it is used, cnt[s] != 0, and not (ZERO_REG && s == 0).
- stall_o = id_valid_i && !flush_i && (busy(src1) || busy(src2)).
- Issue = id_valid_i && !stall_o && !flush_i && !freeze_i.
- Per cycle, when freeze_i = 0, every nonzero cnt decrements by 1; ld clears when cnt reaches 0.
- On issue with wb_en_i = 1 and dest not suppressed by ZERO_REG: cnt[dest_i] loads PIPE_DEPTH and ld[dest_i] loads mem_r_en_i. This overrides the decrement for that register; the newer producer wins.
- Self-dependence (src == dest on an in-flight register): stall takes priority, and no reload happens until issue.
- When freeze_i = 1, nothing is updated: no decrement, no issue, and stall_cycles_o holds. stall_o stays combinationally valid.
- stall_cycles_o increments when stall_o && !freeze_i and saturates at all-ones.
- rst: all cnt = 0, all ld = 0, pending_o = 0, stall_cycles_o = 0. stall_o is then 0 because nothing is pending. Reset mid-operation drops all in-flight tracking at once.

## Timing
- Producer issues in cycle t. From t+1, cnt[dest] = PIPE_DEPTH and pending_o[dest] = 1.
- Without forwarding, a dependent instruction in ID at t+1 stalls PIPE_DEPTH cycles and issues at t+1+PIPE_DEPTH.
- stall_o has zero latency from the inputs. pending_o has one cycle of latency.
- Each cycle of freeze_i extends the remaining countdown by one cycle.

## Configuration
- HAZARD_FWD_EN defined: the EXE/MEM forwarding paths exist.
  - A source is busy only when ld[s] = 1 and cnt[s] == PIPE_DEPTH, i.e. the load-use case.
  - A load-use pair stalls exactly 1 cycle. Non-load producers never stall.
- HAZARD_FWD_EN undefined: no forwarding; busy = cnt[s] != 0, as given in Operation.

## Test plan
- Reset, no forwarding, PIPE_DEPTH=3: issue `add` with dest=5, next instruction reads src1=5 -> stall_o=1 for 3 cycles; issue on the 4th cycle; stall_cycles_o=3.
- is_imm_i=1, st_or_bne_i=0, src2=5 pending -> stall_o=0; same with st_or_bne_i=1 -> stall_o=1.
- With HAZARD_FWD_EN: load dest=7, then a reader of r7 -> exactly 1 stall cycle. ALU dest=7, then a reader of r7 -> 0 stall cycles.
- Load dest=7, then freeze_i=1 for 2 cycles -> pending_o[7] stays high 2 extra cycles; stall_cycles_o unchanged during the freeze.
- ZERO_REG=1: issue writing r0, then a reader of r0 -> pending_o[0]=0, no stall. Flush_i=1 with a busy source -> stall_o=0, no scoreboard update.
- Back-to-back writers of r3, second issued when cnt=1 -> cnt[3] reloads to PIPE_DEPTH. Assert rst mid-countdown -> pending_o=0 the next cycle.
